block_text_gen: RTL and testbench
=================================

Name: block_text_gen

Overview:
- Transmit-side companion to the block-nesting checker. Accepts token commands (WORD, BEGIN, END) over a valid/ready handshake.
- Serialises each token as ASCII bytes, one byte per clock, and follows each token with one space (0x20).
- Tracks the nesting depth of the stream it emits, so the bench or a downstream checker can compare expected and actual balance.

Parameters:
- DEPTH_W, 8, width of the nesting-depth counter. Depth saturates at 2^DEPTH_W-1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd  in  2  command code: 00 WORD, 01 BEGIN, 10 END, 11 reserved (treated as WORD).
- word_len  in  4  WORD length in characters, 0..15; ignored for BEGIN and END.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- out_valid  out  1  out holds a valid character this cycle.
- out  out  8  ASCII character.
- depth  out  DEPTH_W  current nesting depth.
- balanced  out  1  high when depth==0 and err==0.
- err  out  1  sticky error: END at depth 0, or BEGIN at saturated depth.

Behaviour:
- All outputs are registered.
- Reset (reset==0, asynchronous) puts the block in IDLE with these values:
  - cmd_ready=1, out_valid=0, out=8'h00, depth=0, err=0, balanced=1.
- Reset asserted mid-token aborts the token immediately. No partial depth update is applied.
- States:
  - IDLE: cmd_ready=1, out_valid=0.
    - On acceptance, latch cmd and word_len, clear the index counter, go to EMIT.
    - First character appears on out in the cycle after the acceptance edge (latency 1).
  - EMIT: cmd_ready=0, out_valid=1, out = char[idx]; idx increments each cycle.
    - WORD: char[i] = "a"+i, for i=0..word_len-1. Consecutive letters cannot spell "begin" or "end".
    - BEGIN: "b","e","g","i","n" (5 chars).
    - END: "e","n","d" (3 chars).
    - After the last character, go to SEP.
    - WORD with word_len==0 skips EMIT and goes straight to SEP.
  - SEP: out_valid=1, out=" ". Next state is IDLE.
    - Depth update takes effect on the SEP edge:
      - BEGIN: depth+1. If depth==max, depth holds and err is set.
      - END: depth-1. If depth==0, depth holds at 0 and err is set.
      - WORD: no depth change.
- Token occupancy:
  - WORD of length L occupies L+2 cycles (L chars, space, IDLE).
  - BEGIN occupies 7 cycles; END occupies 5.
- cmd_valid while cmd_ready==0 is ignored. No buffering: the source must hold cmd_valid until accepted.
- cmd and word_len are sampled only at acceptance; changes afterwards have no effect.
- err is cleared only by reset.
- balanced is updated in the same cycle as depth and err.
- The idx counter is 4 bits. No wrap is possible because the maximum index is 14.

Optional Feature:
- Macro: BLOCK_TEXT_MIXED_CASE_EN.
- When defined: keyword characters at odd indices are upper-case, giving "bEgIn" and "eNd". WORD characters at odd indices are also upper-case ("aBcD...").
  - Exercises the checker's case-insensitive matching.
- When undefined: all output letters are lower-case.
- Depth and err behaviour are identical in both builds.

Test Plan:
- Reset release, then WORD len=3 → out sequence "a","b","c"," " with out_valid=1 for 4 cycles; cmd_ready returns to 1 on the 5th cycle; depth=0, balanced=1.
- BEGIN, WORD len=2, END, accepted back-to-back → byte stream "begin ab end "; depth reads 1 after the BEGIN space and 0 after the END space; balanced=1, err=0.
- END from reset → bytes "end "; depth stays 0; err=1 and balanced=0 from the SEP edge onward, and both persist through a following BEGIN/END pair.
- DEPTH_W=2: four BEGINs → depth 1,2,3,3; err=1 on the 4th SEP edge.
- cmd_valid toggled and cmd changed during EMIT of BEGIN → output is still exactly "begin "; only one command is accepted.
- reset pulled low during the 3rd character of BEGIN → out_valid=0, depth=0, cmd_ready=1 asynchronously; the next BEGIN emits a full "begin " and depth becomes 1.
- With BLOCK_TEXT_MIXED_CASE_EN defined, BEGIN then END → "bEgIn eNd "; final depth=0, balanced=1.

Source files
------------

// File: rtl/block_text_gen.sv
// Serialises WORD/BEGIN/END tokens as ASCII, one byte per clock, each followed by a space, and tracks nesting depth.
// Optional build macro BLOCK_TEXT_MIXED_CASE_EN upper-cases characters at odd indices.
module block_text_gen #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic [3:0]         word_len,
  output logic               cmd_ready,
  output logic               out_valid,
  output logic [7:0]         out,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, EMIT, SEP} state_t;

  localparam logic [1:0]         CMD_BEGIN = 2'b01;
  localparam logic [1:0]         CMD_END   = 2'b10;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [7:0]         SPACE     = 8'h20;

  state_t               state_reg;
  logic [1:0]           cmd_reg;
  logic [3:0]           len_reg;
  logic [3:0]           idx_reg;
  logic                 cmd_ready_reg;
  logic                 out_valid_reg;
  logic [7:0]           out_reg;
  logic [DEPTH_W-1:0]   depth_reg;
  logic                 err_reg;
  logic                 balanced_reg;

  logic [DEPTH_W-1:0]   depth_next;
  logic                 err_next;
  logic [3:0]           accept_len;

  // Reserved code 2'b11 falls into the default arm and behaves as WORD.
  function automatic logic [7:0] char_of(input logic [1:0] kind, input logic [3:0] i);
    logic [7:0] c;
    c = 8'h00;
    case (kind)
      CMD_BEGIN: begin
        case (i)
          4'd0:    c = "b";
          4'd1:    c = "e";
          4'd2:    c = "g";
          4'd3:    c = "i";
          default: c = "n";
        endcase
      end
      CMD_END: begin
        case (i)
          4'd0:    c = "e";
          4'd1:    c = "n";
          default: c = "d";
        endcase
      end
      default: c = 8'h61 + {4'h0, i};
    endcase
`ifdef BLOCK_TEXT_MIXED_CASE_EN
    if (i[0]) c = c - 8'h20;
`endif
    return c;
  endfunction

  always_comb begin
    case (cmd)
      CMD_BEGIN: accept_len = 4'd5;
      CMD_END:   accept_len = 4'd3;
      default:   accept_len = word_len;
    endcase
  end

  // Depth/err outcome of the token currently held; only committed on the SEP edge.
  always_comb begin
    depth_next = depth_reg;
    err_next   = err_reg;
    if (cmd_reg == CMD_BEGIN) begin
      if (depth_reg == DEPTH_MAX) err_next = 1'b1;
      else                        depth_next = depth_reg + DEPTH_ONE;
    end else if (cmd_reg == CMD_END) begin
      if (depth_reg == '0) err_next = 1'b1;
      else                 depth_next = depth_reg - DEPTH_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cmd_reg       <= 2'b00;
      len_reg       <= 4'd0;
      idx_reg       <= 4'd0;
      cmd_ready_reg <= 1'b1;
      out_valid_reg <= 1'b0;
      out_reg       <= 8'h00;
      depth_reg     <= '0;
      err_reg       <= 1'b0;
      balanced_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            cmd_reg       <= cmd;
            len_reg       <= accept_len;
            idx_reg       <= 4'd0;
            cmd_ready_reg <= 1'b0;
            out_valid_reg <= 1'b1;
            if (accept_len == 4'd0) begin
              state_reg <= SEP;
              out_reg   <= SPACE;
            end else begin
              state_reg <= EMIT;
              out_reg   <= char_of(cmd, 4'd0);
            end
          end
        end
        EMIT: begin
          if (idx_reg == len_reg - 4'd1) begin
            state_reg <= SEP;
            out_reg   <= SPACE;
          end else begin
            idx_reg <= idx_reg + 4'd1;
            out_reg <= char_of(cmd_reg, idx_reg + 4'd1);
          end
        end
        SEP: begin
          state_reg     <= IDLE;
          cmd_ready_reg <= 1'b1;
          out_valid_reg <= 1'b0;
          out_reg       <= 8'h00;
          depth_reg     <= depth_next;
          err_reg       <= err_next;
          balanced_reg  <= (depth_next == '0) && !err_next;
        end
        default: begin
          state_reg     <= IDLE;
          cmd_ready_reg <= 1'b1;
          out_valid_reg <= 1'b0;
          out_reg       <= 8'h00;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign depth     = depth_reg;
  assign err       = err_reg;
  assign balanced  = balanced_reg;

endmodule

// File: tb/tb_block_text_gen.sv
// Directed bench for block_text_gen: a default-width instance plus a DEPTH_W=2 instance for saturation.
module tb_block_text_gen;

  logic       clk;
  logic       reset;
  logic       cmd_valid_m;
  logic       cmd_valid_s;
  logic [1:0] cmd;
  logic [3:0] word_len;

  logic       ready_m, ov_m, bal_m, err_m;
  logic [7:0] out_m;
  logic [7:0] depth_m;
  logic       ready_s, ov_s, bal_s, err_s;
  logic [7:0] out_s;
  logic [1:0] depth_s;

  int n_cmp = 0;
  int n_err = 0;
  bit tgt   = 1'b0;

  block_text_gen #(.DEPTH_W(8)) dut_m (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_m), .cmd(cmd), .word_len(word_len),
    .cmd_ready(ready_m), .out_valid(ov_m), .out(out_m), .depth(depth_m),
    .balanced(bal_m), .err(err_m)
  );

  block_text_gen #(.DEPTH_W(2)) dut_s (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_s), .cmd(cmd), .word_len(word_len),
    .cmd_ready(ready_s), .out_valid(ov_s), .out(out_s), .depth(depth_s),
    .balanced(bal_s), .err(err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire        obs_ready = tgt ? ready_s : ready_m;
  wire        obs_ov    = tgt ? ov_s    : ov_m;
  wire [7:0]  obs_out   = tgt ? out_s   : out_m;
  wire [7:0]  obs_depth = tgt ? {6'd0, depth_s} : depth_m;
  wire        obs_bal   = tgt ? bal_s   : bal_m;
  wire        obs_err   = tgt ? err_s   : err_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string fmt(input string s);
    string r;
    r = s;
`ifdef BLOCK_TEXT_MIXED_CASE_EN
    for (int i = 1; i < r.len(); i += 2)
      if (r.getc(i) >= "a" && r.getc(i) <= "z") r.putc(i, 8'(r.getc(i) - 8'h20));
`endif
    return r;
  endfunction

  task automatic set_valid(input logic v);
    if (tgt) cmd_valid_s = v;
    else     cmd_valid_m = v;
  endtask

  // Called just after a negedge with the target idle; returns at the negedge where it is idle again.
  task automatic run_tok(input string tag, input logic [1:0] c, input logic [3:0] len,
                         input string exp_raw, input bit noise);
    string e;
    e = fmt(exp_raw);
    set_valid(1'b1);
    cmd      = c;
    word_len = len;
    @(negedge clk);
    set_valid(1'b0);
    for (int i = 0; i < e.len(); i++) begin
      chk($sformatf("%s_ov%0d", tag, i), {31'd0, obs_ov}, 32'd1);
      chk($sformatf("%s_ch%0d", tag, i), {24'd0, obs_out}, {24'd0, 8'(e.getc(i))});
      chk($sformatf("%s_rdy%0d", tag, i), {31'd0, obs_ready}, 32'd0);
      if (noise) begin
        set_valid((i % 2) == 0);
        cmd      = 2'b10;
        word_len = 4'd9;
      end
      @(negedge clk);
    end
    set_valid(1'b0);
    chk({tag, "_idle_ov"}, {31'd0, obs_ov}, 32'd0);
    chk({tag, "_idle_rdy"}, {31'd0, obs_ready}, 32'd1);
    $display("token %s done: depth=%0d err=%0b balanced=%0b", tag, obs_depth, obs_err, obs_bal);
  endtask

  task automatic chk_state(input string tag, input int d, input bit e, input bit b);
    chk({tag, "_depth"}, {24'd0, obs_depth}, d);
    chk({tag, "_err"}, {31'd0, obs_err}, {31'd0, e});
    chk({tag, "_bal"}, {31'd0, obs_bal}, {31'd0, b});
  endtask

  initial begin
    reset       = 1'b0;
    cmd_valid_m = 1'b0;
    cmd_valid_s = 1'b0;
    cmd         = 2'b00;
    word_len    = 4'd0;
    @(negedge clk);
    @(negedge clk);

    // Reset values on both instances
    tgt = 1'b0;
    chk("rst_m_rdy", {31'd0, obs_ready}, 32'd1);
    chk("rst_m_ov", {31'd0, obs_ov}, 32'd0);
    chk("rst_m_out", {24'd0, obs_out}, 32'd0);
    chk_state("rst_m", 0, 1'b0, 1'b1);
    tgt = 1'b1;
    chk("rst_s_rdy", {31'd0, obs_ready}, 32'd1);
    chk_state("rst_s", 0, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk);

    // Saturation on the 2-bit instance
    tgt = 1'b1;
    run_tok("sat1", 2'b01, 4'd0, "begin ", 1'b0); chk_state("sat1", 1, 1'b0, 1'b0);
    run_tok("sat2", 2'b01, 4'd0, "begin ", 1'b0); chk_state("sat2", 2, 1'b0, 1'b0);
    run_tok("sat3", 2'b01, 4'd0, "begin ", 1'b0); chk_state("sat3", 3, 1'b0, 1'b0);
    run_tok("sat4", 2'b01, 4'd0, "begin ", 1'b0); chk_state("sat4", 3, 1'b1, 1'b0);

    tgt = 1'b0;
    // WORD len 3, then back-to-back BEGIN / WORD 2 / END
    run_tok("w3", 2'b00, 4'd3, "abc ", 1'b0);   chk_state("w3", 0, 1'b0, 1'b1);
    run_tok("b2b_b", 2'b01, 4'd7, "begin ", 1'b0); chk_state("b2b_b", 1, 1'b0, 1'b0);
    run_tok("b2b_w", 2'b00, 4'd2, "ab ", 1'b0);    chk_state("b2b_w", 1, 1'b0, 1'b0);
    run_tok("b2b_e", 2'b10, 4'd5, "end ", 1'b0);   chk_state("b2b_e", 0, 1'b0, 1'b1);

    // Word-length boundaries and reserved code
    run_tok("w0", 2'b00, 4'd0, " ", 1'b0);                   chk_state("w0", 0, 1'b0, 1'b1);
    run_tok("w15", 2'b00, 4'd15, "abcdefghijklmno ", 1'b0);  chk_state("w15", 0, 1'b0, 1'b1);
    run_tok("rsv", 2'b11, 4'd2, "ab ", 1'b0);                chk_state("rsv", 0, 1'b0, 1'b1);

    // Input noise during EMIT must not disturb the token or be accepted
    run_tok("noise", 2'b01, 4'd0, "begin ", 1'b1);
    chk_state("noise", 1, 1'b0, 1'b0);
    @(negedge clk);
    chk("noise_no2nd_ov", {31'd0, obs_ov}, 32'd0);
    chk("noise_no2nd_rdy", {31'd0, obs_ready}, 32'd1);
    run_tok("noise_e", 2'b10, 4'd0, "end ", 1'b0);  chk_state("noise_e", 0, 1'b0, 1'b1);

    // END at depth 0 sets sticky err
    run_tok("under", 2'b10, 4'd0, "end ", 1'b0);    chk_state("under", 0, 1'b1, 1'b0);
    run_tok("stk_b", 2'b01, 4'd0, "begin ", 1'b0);  chk_state("stk_b", 1, 1'b1, 1'b0);
    run_tok("stk_e", 2'b10, 4'd0, "end ", 1'b0);    chk_state("stk_e", 0, 1'b1, 1'b0);

    // Asynchronous reset during the 3rd character of BEGIN
    cmd_valid_m = 1'b1;
    cmd         = 2'b01;
    @(negedge clk);
    cmd_valid_m = 1'b0;
    chk("ar_c0", {24'd0, out_m}, {24'd0, 8'h62});
    @(negedge clk);
    @(negedge clk);
    chk("ar_ov_before", {31'd0, ov_m}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("ar_ov", {31'd0, ov_m}, 32'd0);
    chk("ar_rdy", {31'd0, ready_m}, 32'd1);
    chk("ar_out", {24'd0, out_m}, 32'd0);
    chk_state("ar", 0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_tok("ar_b", 2'b01, 4'd0, "begin ", 1'b0);  chk_state("ar_b", 1, 1'b0, 1'b0);
    run_tok("ar_e", 2'b10, 4'd0, "end ", 1'b0);    chk_state("ar_e", 0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
